// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet/UDP receive path.
// The fifo_rx block holds one full UDP payload of up to FIFO_RX_MAX_BYTES.
package eth_pkg;

  localparam int FIFO_RX_DEPTH     = 256;
  localparam int FIFO_RX_MAX_BYTES = 1024;
  localparam int FIFO_RX_AW        = $clog2(FIFO_RX_DEPTH);
  localparam int FIFO_RX_DW        = 32;

  typedef enum logic [2:0] {
    FIFO_RX_IDLE,
    FIFO_RX_WR,
    FIFO_RX_CHECK,
    FIFO_RX_RD,
    FIFO_RX_DROP
  } fifo_rx_state_e;

  // A payload is storable only if it is non-empty, whole 32-bit words and fits the buffer.
  function automatic logic fifo_rx_len_ok(input logic [15:0] len);
    return (len != 16'd0) && (len[1:0] == 2'b00) && (len <= 16'(FIFO_RX_MAX_BYTES));
  endfunction

endpackage

// File: rtl/fifo_rx_mem.sv
// Payload storage for fifo_rx: one synchronous write port and one read port
// whose registered output drives the downstream data bus directly.
module fifo_rx_mem
  import eth_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [FIFO_RX_AW-1:0] waddr_i,
  input  logic [FIFO_RX_DW-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [FIFO_RX_AW-1:0] raddr_i,
  output logic [FIFO_RX_DW-1:0] rdata_o
);

  logic [FIFO_RX_DW-1:0] mem_q [FIFO_RX_DEPTH];
  logic [FIFO_RX_DW-1:0] rdata_q;

  // The array itself is never reset; only the output register is.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_rx.sv
// Store-and-forward receive buffer for one UDP payload: the frame is written,
// validated on its tlast beat, then either streamed downstream or dropped.
module fifo_rx
  import eth_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        udp_header_rx_done,
  input  logic [15:0] udp_len,
  output logic        frame_done,
  output logic        frame_drop,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);

  fifo_rx_state_e state_q, state_d;
  logic [13:0]    exp_words_q, exp_words_d;
  logic [8:0]     wr_ptr_q, wr_ptr_d;
  logic [8:0]     rd_ptr_q, rd_ptr_d;
  logic           good_q, good_d;
  logic           m_tvalid_q, m_tvalid_d;
  logic           m_tlast_q, m_tlast_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_drop_q, frame_drop_d;

  logic                  mem_we;
  logic                  mem_re;
  logic [FIFO_RX_AW-1:0] mem_raddr;
  logic [FIFO_RX_DW-1:0] mem_rdata;
  logic                  s_beat;
  logic                  m_beat;
  logic                  wr_full;

  assign s_axis_tready = (state_q == FIFO_RX_WR) || (state_q == FIFO_RX_DROP);
  assign s_beat        = s_axis_tvalid && s_axis_tready;
  assign m_beat        = m_tvalid_q && m_axis_tready;
  assign wr_full       = wr_ptr_q[8];

  always_comb begin
    state_d      = state_q;
    exp_words_d  = exp_words_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    good_d       = good_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    frame_done_d = 1'b0;
    frame_drop_d = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_raddr    = rd_ptr_q[FIFO_RX_AW-1:0];

    case (state_q)
      FIFO_RX_IDLE: begin
        if (udp_header_rx_done) begin
          exp_words_d = udp_len[15:2];
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          state_d     = fifo_rx_len_ok(udp_len) ? FIFO_RX_WR : FIFO_RX_DROP;
        end
      end

      // A full buffer is never written, so an oversize frame cannot clobber mem[0].
      FIFO_RX_WR: begin
        if (s_beat) begin
          if (s_axis_tlast) begin
            mem_we   = !wr_full;
            wr_ptr_d = wr_full ? wr_ptr_q : wr_ptr_q + 9'd1;
            good_d   = !s_axis_tuser && (({5'd0, wr_ptr_q} + 14'd1) == exp_words_q);
            state_d  = FIFO_RX_CHECK;
          end else if (wr_full) begin
            state_d = FIFO_RX_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 9'd1;
          end
        end
      end

      FIFO_RX_CHECK: begin
        if (good_q) begin
          mem_re     = 1'b1;
          mem_raddr  = '0;
          m_tvalid_d = 1'b1;
          m_tlast_d  = (exp_words_q == 14'd1);
          rd_ptr_d   = 9'd1;
          state_d    = FIFO_RX_RD;
        end else begin
          frame_drop_d = 1'b1;
          wr_ptr_d     = '0;
          state_d      = FIFO_RX_IDLE;
        end
      end

      FIFO_RX_RD: begin
        if (m_beat) begin
          if (m_tlast_q) begin
            m_tvalid_d   = 1'b0;
            m_tlast_d    = 1'b0;
            frame_done_d = 1'b1;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            state_d      = FIFO_RX_IDLE;
          end else begin
            mem_re    = 1'b1;
            rd_ptr_d  = rd_ptr_q + 9'd1;
            m_tlast_d = ({5'd0, rd_ptr_q} == (exp_words_q - 14'd1));
          end
        end
      end

      FIFO_RX_DROP: begin
        if (s_beat && s_axis_tlast) begin
          frame_drop_d = 1'b1;
          wr_ptr_d     = '0;
          state_d      = FIFO_RX_IDLE;
        end
      end

      default: begin
        state_d = FIFO_RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= FIFO_RX_IDLE;
      exp_words_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      good_q       <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_words_q  <= exp_words_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      good_q       <= good_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      frame_done_q <= frame_done_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  fifo_rx_mem u_mem (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[FIFO_RX_AW-1:0]),
    .wdata_i (s_axis_tdata),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign m_axis_tdata  = mem_rdata;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign frame_done    = frame_done_q;
  assign frame_drop    = frame_drop_q;

endmodule

// File: tb/tb_fifo_rx.sv
// Directed bench for fifo_rx: expected words and frame events are queued as
// stimulus is issued and a negedge monitor pops and compares them.
module tb_fifo_rx;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        udp_header_rx_done = 1'b0;
  logic [15:0] udp_len = '0;
  logic        frame_done;
  logic        frame_drop;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;

  int          vecCount = 0;
  int          missCount = 0;
  int          cyc = 0;
  int          beatCyc = 0;
  logic [32:0] expWords[$];
  logic [32:0] expEvents[$];
  logic [33:0] beatQ[$];
  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic        prevLast = 1'b0;
  logic [31:0] prevData = '0;
  logic        readyPat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  fifo_rx dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .udp_header_rx_done (udp_header_rx_done),
    .udp_len            (udp_len),
    .frame_done         (frame_done),
    .frame_drop         (frame_drop),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tready      (s_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic flagFail(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
    end else begin
      if (frame_done && frame_drop) flagFail("done_and_drop_together");
      if (frame_done || frame_drop) begin
        if (expEvents.size() == 0) flagFail(frame_done ? "unexpected_frame_done" : "unexpected_frame_drop");
        else checkOutput("frame_event", frame_drop ? 33'd2 : 33'd1, expEvents.pop_front());
      end
      if (prevValid && !prevReady) begin
        checkOutput("stall_valid_held", {32'd0, m_axis_tvalid}, 33'd1);
        checkOutput("stall_data_held", {m_axis_tlast, m_axis_tdata}, {prevLast, prevData});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expWords.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL unexpected_word: got 0x%0h last=%0b, required none", m_axis_tdata, m_axis_tlast);
        end else begin
          checkOutput("m_axis_word", {m_axis_tlast, m_axis_tdata}, expWords.pop_front());
        end
      end
      prevValid = m_axis_tvalid;
      prevReady = m_axis_tready;
      prevLast  = m_axis_tlast;
      prevData  = m_axis_tdata;
    end
  end

  task automatic sendHeader(input logic [15:0] len);
    udp_len            = len;
    udp_header_rx_done = 1'b1;
    @(posedge aclk);
    #1;
    udp_header_rx_done = 1'b0;
  endtask

  task automatic sendBeat(input logic [31:0] data, input logic last, input logic user);
    int n;
    s_axis_tdata  = data;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    for (n = 0; n < 64; n++) begin
      @(negedge aclk);
      if (s_axis_tready) break;
    end
    if (n == 64) flagFail("s_axis_tready_timeout");
    else beatCyc = cyc;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] len);
    sendHeader(len);
    foreach (beatQ[i]) sendBeat(beatQ[i][31:0], beatQ[i][32], beatQ[i][33]);
    beatQ.delete();
  endtask

  task automatic waitDrain(input string name);
    int n;
    for (n = 0; n < 200; n++) begin
      @(posedge aclk);
      #1;
      if (expWords.size() == 0 && expEvents.size() == 0) break;
    end
    checkOutput(name, 33'(expWords.size() + expEvents.size()), 33'd0);
    expWords.delete();
    expEvents.delete();
    repeat (5) @(posedge aclk);
    #1;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_ctrl"}, {28'd0, s_axis_tready, m_axis_tvalid, m_axis_tlast, frame_done, frame_drop}, 33'd0);
    checkOutput({name, "_tdata"}, {1'b0, m_axis_tdata}, 33'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge aclk);
    #1;
    checkResetOutputs("reset");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("idle_tready", {32'd0, s_axis_tready}, 33'd0);

    $display("[TB] scenario 1: 16-byte good frame, latency check");
    expWords.push_back({1'b0, 32'h1111_1111});
    expWords.push_back({1'b0, 32'h2222_2222});
    expWords.push_back({1'b0, 32'h3333_3333});
    expWords.push_back({1'b1, 32'h4444_4444});
    expEvents.push_back(33'd1);
    beatQ.push_back({2'b00, 32'h1111_1111});
    beatQ.push_back({2'b00, 32'h2222_2222});
    beatQ.push_back({2'b00, 32'h3333_3333});
    beatQ.push_back({2'b01, 32'h4444_4444});
    applyStimulus(16'd16);
    for (n = 0; n < 10; n++) begin
      @(negedge aclk);
      if (m_axis_tvalid) break;
    end
    checkOutput("first_valid_latency", 33'(cyc - beatCyc), 33'd2);
    waitDrain("s1_drain");

    $display("[TB] scenario 2: 16-byte header, three beats");
    expEvents.push_back(33'd2);
    beatQ.push_back({2'b00, 32'hAAAA_0001});
    beatQ.push_back({2'b00, 32'hAAAA_0002});
    beatQ.push_back({2'b01, 32'hAAAA_0003});
    applyStimulus(16'd16);
    waitDrain("s2_drain");

    $display("[TB] scenario 3: 8-byte frame with tuser on tlast");
    expEvents.push_back(33'd2);
    beatQ.push_back({2'b00, 32'hBBBB_0001});
    beatQ.push_back({2'b11, 32'hBBBB_0002});
    applyStimulus(16'd8);
    waitDrain("s3_drain");

    $display("[TB] scenario 4: udp_len 6 and 1028 are sunk and dropped");
    expEvents.push_back(33'd2);
    beatQ.push_back({2'b00, 32'hCCCC_0001});
    beatQ.push_back({2'b01, 32'hCCCC_0002});
    applyStimulus(16'd6);
    waitDrain("s4_len6_drain");
    expEvents.push_back(33'd2);
    beatQ.push_back({2'b01, 32'hCCCC_0003});
    applyStimulus(16'd1028);
    waitDrain("s4_len1028_drain");

    $display("[TB] scenario 5: 12-byte frame with downstream stalls");
    m_axis_tready = 1'b0;
    expWords.push_back({1'b0, 32'hD00D_0001});
    expWords.push_back({1'b0, 32'hD00D_0002});
    expWords.push_back({1'b1, 32'hD00D_0003});
    expEvents.push_back(33'd1);
    sendHeader(16'd12);
    sendBeat(32'hD00D_0001, 1'b0, 1'b0);
    sendHeader(16'd0);
    sendBeat(32'hD00D_0002, 1'b0, 1'b0);
    sendBeat(32'hD00D_0003, 1'b1, 1'b0);
    for (n = 0; n < 10; n++) begin
      @(posedge aclk);
      #1;
      if (m_axis_tvalid) break;
    end
    checkOutput("s5_valid_seen", {32'd0, m_axis_tvalid}, 33'd1);
    for (int i = 0; i < 6; i++) begin
      m_axis_tready = readyPat[i];
      @(posedge aclk);
      #1;
    end
    m_axis_tready = 1'b1;
    waitDrain("s5_drain");

    $display("[TB] scenario 6: reset during beat 2 of 4, then 8-byte frame");
    sendHeader(16'd16);
    sendBeat(32'hEEEE_0001, 1'b0, 1'b0);
    s_axis_tdata  = 32'hEEEE_0002;
    s_axis_tvalid = 1'b1;
    aresetn       = 1'b0;
    @(posedge aclk);
    #1;
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    checkResetOutputs("midframe_reset");
    repeat (3) @(posedge aclk);
    #1;
    expWords.push_back({1'b0, 32'hF00D_CAFE});
    expWords.push_back({1'b1, 32'h0BAD_BEEF});
    expEvents.push_back(33'd1);
    beatQ.push_back({2'b00, 32'hF00D_CAFE});
    beatQ.push_back({2'b01, 32'h0BAD_BEEF});
    applyStimulus(16'd8);
    waitDrain("s6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/fifo_rx.md
FIFO_RX -- requirements
Module: fifo_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: aclk input 1 (all logic on its rising edge); aresetn input 1 (synchronous, active-low).
REQ-002 Header-side ports SHALL be:
- udp_header_rx_done  input  1  single-cycle pulse; header parsed, udp_len valid
- udp_len  input  16  UDP payload length in bytes, valid with udp_header_rx_done
- frame_done  output  1  one-cycle pulse; frame fully delivered downstream
- frame_drop  output  1  one-cycle pulse; frame discarded
REQ-003 Upstream AXI-Stream ports SHALL be:
- s_axis_tdata  input  32  payload word
- s_axis_tvalid  input  1  word valid
- s_axis_tlast  input  1  last word of payload
- s_axis_tuser  input  1  error flag (bad FCS or bad checksum), sampled on the tlast beat
- s_axis_tready  output  1  block ready
REQ-004 Downstream AXI-Stream ports SHALL be:
- m_axis_tdata  output  32  payload word
- m_axis_tvalid  output  1  word valid
- m_axis_tlast  output  1  last word
- m_axis_tready  input  1  downstream ready

Function
REQ-005 The block SHALL store one complete payload in a 256 x 32 buffer and release it downstream only after the whole frame is received and validated (store-and-forward).
REQ-006 The FSM SHALL have the states IDLE, WR, CHECK, RD and DROP.
REQ-007 In IDLE, on udp_header_rx_done:
- latch udp_len into exp_words = udp_len[15:2]
- go to DROP if udp_len == 0, udp_len[1:0] != 0, or udp_len > 1024
- otherwise go to WR
REQ-008 s_axis_tready SHALL be 1 only in WR and DROP, and 0 in all other states.
REQ-009 In WR, each beat (tvalid && tready) SHALL write mem[wr_ptr] and increment wr_ptr, a 9-bit word count.
REQ-010 On the WR tlast beat, the block SHALL go to CHECK and register good = !s_axis_tuser && (wr_ptr + 1 == exp_words).
REQ-011 If a beat arrives in WR with wr_ptr == 256 and no tlast, the block SHALL go to DROP without writing (overflow).
REQ-012 DROP SHALL accept and discard beats until a tlast beat, then return to IDLE with frame_drop = 1 for one cycle.
REQ-013 In CHECK with good == 0, the block SHALL pulse frame_drop for one cycle and return to IDLE; no m_axis beat is emitted.
REQ-014 In CHECK with good == 1, the block SHALL register mem[0] onto m_axis_tdata, assert m_axis_tvalid, set m_axis_tlast = (exp_words == 1), set rd_ptr = 1, and go to RD.
- Latency: s_axis tlast beat at cycle N gives first m_axis_tvalid at cycle N+2.
REQ-015 In RD, m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL stay stable while m_axis_tready == 0.
REQ-016 In RD, on each non-last handshake the block SHALL load mem[rd_ptr], increment rd_ptr, and set m_axis_tlast when rd_ptr == exp_words - 1.
- Throughput: one word per cycle under continuous m_axis_tready.
REQ-017 On the tlast handshake, the block SHALL:
- deassert m_axis_tvalid and m_axis_tlast on the next cycle
- pulse frame_done
- clear wr_ptr and rd_ptr
- return to IDLE
REQ-018 udp_header_rx_done outside IDLE SHALL be ignored.
REQ-019 s_axis beats in IDLE, CHECK or RD SHALL not be accepted (tready == 0), so upstream stalls.
REQ-020 frame_done and frame_drop SHALL never be asserted in the same cycle.

Reset
REQ-021 While aresetn == 0 at a clock edge, the block SHALL:
- set state IDLE
- set s_axis_tready, m_axis_tvalid, m_axis_tlast, frame_done, frame_drop, wr_ptr, rd_ptr and exp_words to 0
- set m_axis_tdata to 0
REQ-022 Reset mid-frame SHALL discard the partial frame with no frame_drop pulse; buffer contents are not cleared.

Structure
REQ-023 Package eth_pkg SHALL hold FIFO_RX_DEPTH = 256, FIFO_RX_MAX_BYTES = 1024 and the fifo_rx state enum.
REQ-024 Storage SHALL be the sub-module fifo_rx_mem: 256 x 32, one synchronous write port, one read port with registered output.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- udp_len = 16, four beats 0x11111111..0x44444444, tlast on beat 4, tuser = 0, m_axis_tready = 1: same four words out from cycle N+2, tlast on 4th word, one frame_done.
- udp_len = 16 with only three beats (tlast on 3rd): no m_axis_tvalid, one frame_drop.
- udp_len = 8, two beats, tuser = 1 on tlast: frame_drop, no output.
- udp_len = 6: all beats sunk with tready = 1 until tlast, then frame_drop.
- udp_len = 12, m_axis_tready toggling 1,0,0,1,0,1: data held stable during stalls, 3 words in order, frame_done after the 3rd handshake.
- aresetn = 0 during WR beat 2 of 4: all outputs 0 and state IDLE next cycle; the next valid 8-byte frame passes correctly.
